// File: rtl/synch_pkg.sv
// Shared definitions for the synchronisation-register requester.
// Contents: memory packet type codes, core command opcodes, requester FSM states,
// and the register-index-to-byte-offset helper.
package synch_pkg;

  // Request packet types
  localparam logic [2:0] PKT_READ      = 3'b010;
  localparam logic [2:0] PKT_WRITE     = 3'b111;
  localparam logic [2:0] PKT_FADD      = 3'b100;
  // Response packet types
  localparam logic [2:0] PKT_RSP_RDATA = 3'b101;
  localparam logic [2:0] PKT_RSP_WACK  = 3'b110;

  // Synch registers are 32-bit words, so index -> byte offset is a shift by 2
  localparam int unsigned RegAddrShift = 2;

  typedef enum logic [1:0] {
    OpRead    = 2'b00,
    OpWrite   = 2'b01,
    OpFadd    = 2'b10,
    OpBarrier = 2'b11
  } cmd_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StWait,
    StGap
  } state_e;

  function automatic logic [35:0] reg_offset(input logic [1:0] idx);
    return 36'(idx) << RegAddrShift;
  endfunction

endpackage

// File: rtl/synch_requester.sv
// synch_requester: turns one core command (read / write / fetch-add / barrier) on a
// synch register into memory request packets, waits for the response with the matching
// id and pulses a completion with the returned register value.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   cmd_valid/cmd_ready      core command handshake (ready only when idle)
//   cmd_op/cmd_reg           opcode (synch_pkg::cmd_op_e) and register index
//   cmd_wdata/cmd_inc        write value or barrier target / signed fetch-add increment
//   done_valid/done_data     one-cycle completion pulse with register value
//   req_valid/req_ready      memory request handshake
//   *_req_out                request address, data, id, packet type
//   rsp_*                    memory response
//   retry_cnt                saturating reissue count (SYNCH_REQ_TIMEOUT_EN only)
//
// Build option: define SYNCH_REQ_TIMEOUT_EN to reissue a request (new id, same fields)
// after 1023 cycles in WAIT without a matching response.
module synch_requester
  import synch_pkg::*;
#(
  parameter int unsigned DEPTH      = 512,
  parameter logic [35:0] SYNCH_BASE = 36'h0,
  parameter int unsigned POLL_GAP   = 8
) (
  input  logic             clk,
  input  logic             rst,
`ifdef SYNCH_REQ_TIMEOUT_EN
  output logic [7:0]       retry_cnt,
`endif
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [1:0]       cmd_reg,
  input  logic [31:0]      cmd_wdata,
  input  logic [14:0]      cmd_inc,
  output logic             done_valid,
  output logic [31:0]      done_data,
  output logic             req_valid,
  input  logic             req_ready,
  output logic [35:0]      addr_req_out,
  output logic [DEPTH-1:0] data_req_out,
  output logic [3:0]       id_req_out,
  output logic [2:0]       packet_type_req_out,
  input  logic             rsp_valid,
  input  logic [3:0]       rsp_id,
  input  logic [2:0]       rsp_packet_type,
  input  logic [DEPTH-1:0] rsp_data
);

  state_e           r_state, w_state_next;
  cmd_op_e          r_op;
  logic [31:0]      r_target;
  logic             r_polling;  // barrier: fetch-add done, now read-polling
  logic [3:0]       r_id;       // free-running id counter
  logic [3:0]       r_id_out;   // id of the request in flight
  logic [35:0]      r_addr;
  logic [DEPTH-1:0] r_data;
  logic [2:0]       r_type;
  logic [15:0]      r_gap_cnt;
  logic             r_done_valid;
  logic [31:0]      r_done_data;

  logic [DEPTH-1:0] w_cmd_data;
  logic [2:0]       w_cmd_type;
  logic             w_accept, w_req_fire, w_rsp_match, w_poll_met;
  logic             w_start_poll, w_to_gap, w_done, w_enter_send, w_timeout;
  logic             w_unused_rsp;

  // Response type is informational only: any matching id completes the request.
  assign w_unused_rsp = ^{rsp_packet_type, rsp_data[DEPTH-1:32], PKT_RSP_RDATA, PKT_RSP_WACK};

  always_comb begin
    w_cmd_data = '0;
    w_cmd_type = PKT_READ;
    unique case (cmd_op_e'(cmd_op))
      OpRead: w_cmd_type = PKT_READ;
      OpWrite: begin
        w_cmd_type       = PKT_WRITE;
        w_cmd_data[31:0] = cmd_wdata;
      end
      OpFadd: begin
        w_cmd_type        = PKT_FADD;
        w_cmd_data[46:32] = cmd_inc;
      end
      OpBarrier: begin
        // Barrier arrives with fetch-add +1; cmd_wdata is the target, not data
        w_cmd_type        = PKT_FADD;
        w_cmd_data[46:32] = 15'd1;
      end
      default: w_cmd_type = PKT_READ;
    endcase
  end

  assign w_accept     = (r_state == StIdle) && cmd_valid;
  assign w_req_fire   = (r_state == StSend) && req_ready;
  assign w_rsp_match  = (r_state == StWait) && rsp_valid && (rsp_id == r_id_out);
  assign w_poll_met   = rsp_data[31:0] >= r_target;
  assign w_start_poll = w_rsp_match && (r_op == OpBarrier) && !r_polling && (r_target > 32'd1);
  assign w_to_gap     = w_rsp_match && (r_op == OpBarrier) && r_polling && !w_poll_met;
  assign w_done       = w_rsp_match && !w_start_poll && !w_to_gap;

`ifdef SYNCH_REQ_TIMEOUT_EN
  logic [9:0] r_wait_cnt;
  logic [7:0] r_retry_cnt;

  // Fires on the 1023rd WAIT cycle without a matching response
  assign w_timeout = (r_state == StWait) && !w_rsp_match && (r_wait_cnt == 10'd1022);
  assign retry_cnt = r_retry_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait_cnt  <= '0;
      r_retry_cnt <= '0;
    end else begin
      if (w_req_fire) begin
        r_wait_cnt <= '0;
      end else if (r_state == StWait) begin
        r_wait_cnt <= r_wait_cnt + 10'd1;
      end
      if (w_timeout && (r_retry_cnt != 8'hFF)) begin
        r_retry_cnt <= r_retry_cnt + 8'd1;
      end
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: if (cmd_valid) w_state_next = StSend;
      StSend: if (req_ready) w_state_next = StWait;
      StWait: begin
        if (w_rsp_match) begin
          if (w_to_gap)          w_state_next = StGap;
          else if (w_start_poll) w_state_next = StSend;
          else                   w_state_next = StIdle;
        end else if (w_timeout) begin
          w_state_next = StSend;
        end
      end
      StGap: if (r_gap_cnt == '0) w_state_next = StSend;
      default: w_state_next = StIdle;
    endcase
  end

  assign w_enter_send = (w_state_next == StSend) && (r_state != StSend);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op         <= OpRead;
      r_target     <= '0;
      r_polling    <= 1'b0;
      r_id         <= '0;
      r_id_out     <= '0;
      r_addr       <= '0;
      r_data       <= '0;
      r_type       <= '0;
      r_gap_cnt    <= '0;
      r_done_valid <= 1'b0;
      r_done_data  <= '0;
    end else begin
      r_done_valid <= 1'b0;
      if (w_enter_send) r_id_out <= r_id;
      if (w_req_fire)   r_id     <= r_id + 4'd1;
      if (w_accept) begin
        r_op      <= cmd_op_e'(cmd_op);
        r_target  <= cmd_wdata;
        r_polling <= 1'b0;
        r_addr    <= SYNCH_BASE + reg_offset(cmd_reg);
        r_data    <= w_cmd_data;
        r_type    <= w_cmd_type;
      end
      if (w_start_poll) begin
        r_polling <= 1'b1;
        r_type    <= PKT_READ;
        r_data    <= '0;
      end
      if (w_to_gap) begin
        r_gap_cnt <= 16'(POLL_GAP - 1);
      end else if (r_state == StGap) begin
        r_gap_cnt <= r_gap_cnt - 16'd1;
      end
      if (w_done) begin
        r_done_valid <= 1'b1;
        r_done_data  <= rsp_data[31:0];
      end
    end
  end

  assign cmd_ready           = (r_state == StIdle);
  assign req_valid           = (r_state == StSend);
  assign addr_req_out        = r_addr;
  assign data_req_out        = r_data;
  assign id_req_out          = r_id_out;
  assign packet_type_req_out = r_type;
  assign done_valid          = r_done_valid;
  assign done_data           = r_done_data;

endmodule
